// File: rtl/adder_chunk.sv
// Combinational N-bit ripple-carry chunk built from full_adder cells.
// It also exposes the carry into the top bit, which the overflow logic needs.
module adder_chunk #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] s,
    output logic         cout,
    output logic         c_msb_in
);

    logic [N:0] c_s;

    assign c_s[0] = cin;

    for (genvar i = 0; i < N; i++) begin : g_bit
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (c_s[i]),
            .s    (s[i]),
            .cout (c_s[i+1])
        );
    end

    assign cout     = c_s[N];
    assign c_msb_in = c_s[N-1];

endmodule

// File: rtl/full_adder.sv
// One-bit full adder. This is the leaf cell that every ripple chain in the
// adder pipeline is built from.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit adder/subtractor. Each of the STAGES stages adds one
// CHUNK-wide slice, and a registered carry passes between the stages.
module pipelined_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CHUNK = (STAGES > 0) ? (WIDTH / STAGES) : WIDTH;

    if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_cfg
        $error("pipelined_adder: STAGES must be >= 1 and divide WIDTH");
    end

    logic                          advance_s;
    logic                          accept_s;
    logic [STAGES-1:0]             valid_r;
    logic [STAGES-1:0]             carry_r;
    logic [STAGES-1:0][WIDTH-1:0]  a_r;
    logic [STAGES-1:0][WIDTH-1:0]  b_r;
    logic [STAGES-1:0][WIDTH-1:0]  sum_r;
    logic                          ovf_r;

    logic [STAGES-1:0][WIDTH-1:0]  src_a_s;
    logic [STAGES-1:0][WIDTH-1:0]  src_b_s;
    logic [STAGES-1:0][WIDTH-1:0]  src_sum_s;
    logic [STAGES-1:0][WIDTH-1:0]  next_sum_s;
    logic [STAGES-1:0]             src_c_s;
    logic [STAGES-1:0]             src_v_s;
    logic [STAGES-1:0]             co_s;
    logic [STAGES-1:0]             cm_s;
    logic [STAGES-1:0][CHUNK-1:0]  cs_s;

    // Global stall: the whole pipe moves together or holds entirely.
    always_comb begin
        advance_s = !valid_r[STAGES-1] || out_ready;
        accept_s  = in_valid && advance_s;
    end

    assign in_ready = advance_s;

    // Select each stage's inputs: stage 0 takes the ports, later stages take the previous register.
    always_comb begin
        src_a_s   = '0;
        src_b_s   = '0;
        src_sum_s = '0;
        src_c_s   = '0;
        src_v_s   = '0;
        src_v_s[0] = accept_s;
        // Bubbles load zeros so that idle stages hold known data.
        if (accept_s) begin
            src_a_s[0] = a;
            src_b_s[0] = sub ? ~b : b;
            src_c_s[0] = sub ? 1'b1 : cin;
        end else begin
            src_a_s[0] = '0;
            src_b_s[0] = '0;
            src_c_s[0] = 1'b0;
        end
        for (int k = 1; k < STAGES; k++) begin
            src_v_s[k]   = valid_r[k-1];
            src_a_s[k]   = a_r[k-1];
            src_b_s[k]   = b_r[k-1];
            src_sum_s[k] = sum_r[k-1];
            src_c_s[k]   = carry_r[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        adder_chunk #(.N(CHUNK)) u_chunk (
            .a        (src_a_s[k][k*CHUNK +: CHUNK]),
            .b        (src_b_s[k][k*CHUNK +: CHUNK]),
            .cin      (src_c_s[k]),
            .s        (cs_s[k]),
            .cout     (co_s[k]),
            .c_msb_in (cm_s[k])
        );
    end

    // Insert this stage's chunk result into the partial sum that moves down the pipe.
    always_comb begin
        next_sum_s = src_sum_s;
        for (int k = 0; k < STAGES; k++) begin
            next_sum_s[k][k*CHUNK +: CHUNK] = cs_s[k];
        end
    end

    // Stage registers. The last stage's registers drive the outputs directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= '0;
            carry_r <= '0;
            a_r     <= '0;
            b_r     <= '0;
            sum_r   <= '0;
            ovf_r   <= 1'b0;
        end else if (advance_s) begin
            valid_r <= src_v_s;
            carry_r <= co_s;
            a_r     <= src_a_s;
            b_r     <= src_b_s;
            sum_r   <= next_sum_s;
            ovf_r   <= cm_s[STAGES-1] ^ co_s[STAGES-1];
        end else begin
            valid_r <= valid_r;
            carry_r <= carry_r;
            a_r     <= a_r;
            b_r     <= b_r;
            sum_r   <= sum_r;
            ovf_r   <= ovf_r;
        end
    end

    assign out_valid = valid_r[STAGES-1];
    assign sum       = sum_r[STAGES-1];
    assign cout      = carry_r[STAGES-1];
    assign ovf       = ovf_r;

endmodule
